// File: rtl/decode_queue.sv
// decode_queue: first-word-fall-through queue between decode and issue.
// Each entry holds one decoded bundle (pc, raw instruction, control signals,
// ALU op, immediate). All outputs, including the head bundle, come straight
// from registers, so in_ready and out_valid never depend combinationally on
// the handshake inputs. A flush drops every entry in one cycle without
// touching the entry storage.
module decode_queue #(
   parameter int ADDR_WIDTH    = 12,
   parameter int INSTR_WIDTH   = 32,
   parameter int C_SIG_WIDTH   = 7,
   parameter int ALU_SIG_WIDTH = 3,
   parameter int IMM_WIDTH     = 32,
   parameter int DEPTH         = 4
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [ADDR_WIDTH-1:0]        pc_in,
   input  logic [INSTR_WIDTH-1:0]       instr_in,
   input  logic [C_SIG_WIDTH-1:0]       c_sig_in,
   input  logic [ALU_SIG_WIDTH-1:0]     alu_sig_in,
   input  logic [IMM_WIDTH-1:0]         imm_in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ADDR_WIDTH-1:0]        pc_out,
   output logic [INSTR_WIDTH-1:0]       instr_out,
   output logic [C_SIG_WIDTH-1:0]       c_sig_out,
   output logic [ALU_SIG_WIDTH-1:0]     alu_sig_out,
   output logic [IMM_WIDTH-1:0]         imm_out,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W    = $clog2(DEPTH + 1);
   localparam int BUNDLE_W = ADDR_WIDTH + INSTR_WIDTH + C_SIG_WIDTH + ALU_SIG_WIDTH + IMM_WIDTH;

   localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [PTR_W-1:0]    PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0]    PTR_ZERO = {PTR_W{1'b0}};
   localparam logic [BUNDLE_W-1:0] BND_ZERO = {BUNDLE_W{1'b0}};

   logic [BUNDLE_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]    head_r;
   logic [PTR_W-1:0]    tail_r;
   logic [CNT_W-1:0]    count_r;
   logic                full_r;
   logic                empty_r;
   logic [BUNDLE_W-1:0] out_bundle_r;

   logic                push_s;
   logic                pop_s;
   logic [PTR_W-1:0]    head_next_s;
   logic [PTR_W-1:0]    tail_next_s;
   logic [CNT_W-1:0]    count_next_s;
   logic [BUNDLE_W-1:0] in_bundle_s;
   logic [BUNDLE_W-1:0] head_data_s;

   assign in_bundle_s = {pc_in, instr_in, c_sig_in, alu_sig_in, imm_in};

   // Handshakes qualified by registered state only; flush overrides both.
   assign push_s = in_valid & ~full_r & ~flush;
   assign pop_s  = out_ready & ~empty_r & ~flush;

   // Next pointer and occupancy values; pointers wrap naturally (DEPTH is a power of two).
   always_comb begin
      head_next_s  = head_r;
      tail_next_s  = tail_r;
      count_next_s = count_r;
      if (flush) begin
         head_next_s  = PTR_ZERO;
         tail_next_s  = PTR_ZERO;
         count_next_s = CNT_ZERO;
      end else begin
         if (push_s) begin
            tail_next_s = tail_r + PTR_ONE;
         end else begin
            tail_next_s = tail_r;
         end
         if (pop_s) begin
            head_next_s = head_r + PTR_ONE;
         end else begin
            head_next_s = head_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
         endcase
      end
   end

   // Bundle that will sit at the head after this edge; a push into the head slot writes through.
   always_comb begin
      head_data_s = BND_ZERO;
      if (count_next_s == CNT_ZERO) begin
         head_data_s = BND_ZERO;
      end else if (push_s && (tail_r == head_next_s)) begin
         head_data_s = in_bundle_s;
      end else begin
         head_data_s = mem_r[head_next_s];
      end
   end

   // Entry storage: written at the tail on push, cleared only by reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= BND_ZERO;
         end
      end else if (push_s) begin
         mem_r[tail_r] <= in_bundle_s;
      end
   end

   // Pointers, occupancy, status flags and registered head bundle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         head_r       <= PTR_ZERO;
         tail_r       <= PTR_ZERO;
         count_r      <= CNT_ZERO;
         full_r       <= 1'b0;
         empty_r      <= 1'b1;
         out_bundle_r <= BND_ZERO;
      end else begin
         head_r       <= head_next_s;
         tail_r       <= tail_next_s;
         count_r      <= count_next_s;
         full_r       <= (count_next_s == CNT_MAX);
         empty_r      <= (count_next_s == CNT_ZERO);
         out_bundle_r <= head_data_s;
      end
   end

   assign {pc_out, instr_out, c_sig_out, alu_sig_out, imm_out} = out_bundle_r;
   assign in_ready  = ~full_r;
   assign out_valid = ~empty_r;
   assign count     = count_r;
   assign full      = full_r;
   assign empty     = empty_r;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: an ordered list of expected bundles
// models the queue; a monitor compares DUT outputs against it every cycle.
module tb_decode_queue;

   localparam int AW    = 12;
   localparam int IW    = 32;
   localparam int CW    = 7;
   localparam int LW    = 3;
   localparam int MW    = 32;
   localparam int DEPTH = 4;
   localparam int CNTW  = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [IW-1:0] instr;
      logic [CW-1:0] c;
      logic [LW-1:0] alu;
      logic [MW-1:0] imm;
   } bundle_t;

   localparam int BW = $bits(bundle_t);

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic flush = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   bundle_t in_b = '0;

   logic            in_ready, out_valid, full, empty;
   logic [AW-1:0]   pc_out;
   logic [IW-1:0]   instr_out;
   logic [CW-1:0]   c_sig_out;
   logic [LW-1:0]   alu_sig_out;
   logic [MW-1:0]   imm_out;
   logic [CNTW-1:0] count;

   always #5 clk = ~clk;

   decode_queue #(
      .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .C_SIG_WIDTH(CW),
      .ALU_SIG_WIDTH(LW), .IMM_WIDTH(MW), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rstn(rstn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .pc_in(in_b.pc), .instr_in(in_b.instr), .c_sig_in(in_b.c),
      .alu_sig_in(in_b.alu), .imm_in(in_b.imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .pc_out(pc_out), .instr_out(instr_out), .c_sig_out(c_sig_out),
      .alu_sig_out(alu_sig_out), .imm_out(imm_out),
      .count(count), .full(full), .empty(empty)
   );

   bundle_t exp_q[$];
   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference queue: reset or flush empties it, otherwise pop the head if
   // consumer ready and push the bundle if there was room before this edge.
   always @(negedge rstn) exp_q.delete();

   always @(posedge clk) begin
      if (rstn) begin
         if (flush) begin
            exp_q.delete();
         end else begin
            automatic bit do_pop  = (exp_q.size() > 0) && out_ready;
            automatic bit do_push = in_valid && (exp_q.size() < DEPTH);
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(in_b);
         end
      end
   end

   // Monitor: compare status and head bundle against the reference each cycle.
   always @(negedge clk) begin
      if (rstn) begin
         check("mon_count", 128'(count), 128'(exp_q.size()));
         check("mon_out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
         check("mon_in_ready", 128'(in_ready), 128'(exp_q.size() < DEPTH));
         check("mon_full", 128'(full), 128'(exp_q.size() == DEPTH));
         check("mon_empty", 128'(empty), 128'(exp_q.size() == 0));
         if (exp_q.size() > 0)
            check("mon_head", 128'({pc_out, instr_out, c_sig_out, alu_sig_out, imm_out}), 128'(exp_q[0]));
         else
            check("mon_zero", 128'({pc_out, instr_out, c_sig_out, alu_sig_out, imm_out}), 128'(0));
      end
   end

   function automatic bundle_t rnd_bundle();
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      return bundle_t'(r[BW-1:0]);
   endfunction

   function automatic bundle_t mk(input int pc);
      bundle_t b;
      b = rnd_bundle();
      b.pc = AW'(pc);
      return b;
   endfunction

   // One clock of stimulus: drive at a falling edge, return at the next one.
   task automatic cycle(input logic v, input bundle_t b, input logic r, input logic f);
      in_valid  = v;
      in_b      = b;
      out_ready = r;
      flush     = f;
      @(negedge clk);
   endtask

   initial begin
      bundle_t b;
      #12;
      check("rst_count", 128'(count), 128'(0));
      check("rst_empty", 128'(empty), 128'(1));
      check("rst_full", 128'(full), 128'(0));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_in_ready", 128'(in_ready), 128'(1));
      check("rst_fields", 128'({pc_out, instr_out, c_sig_out, alu_sig_out, imm_out}), 128'(0));
      @(negedge clk);
      rstn = 1'b1;

      // Fill to full; fifth bundle refused.
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, mk(4 * (i + 1)), 1'b0, 1'b0);
         check("fill_count", 128'(count), 128'(i + 1));
      end
      check("fill_full", 128'(full), 128'(1));
      check("fill_in_ready", 128'(in_ready), 128'(0));
      cycle(1'b1, mk(12'h014), 1'b0, 1'b0);
      check("fifth_rejected_count", 128'(count), 128'(4));

      // Drain in order.
      for (int i = 0; i < 4; i++) begin
         check("drain_pc", 128'(pc_out), 128'(4 * (i + 1)));
         cycle(1'b0, '0, 1'b1, 1'b0);
      end
      check("drain_empty", 128'(empty), 128'(1));
      check("drain_pc_zero", 128'(pc_out), 128'(0));

      // Streaming: 10 bundles through, occupancy stays at one.
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, mk(12'h100 + i), 1'b1, 1'b0);
         check("stream_count", 128'(count), 128'(1));
         check("stream_pc", 128'(pc_out), 128'(12'h100 + i));
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
      check("stream_drained", 128'(count), 128'(0));

      // Flush with three held and a coincident push.
      for (int i = 0; i < 3; i++) cycle(1'b1, mk(12'h200 + i), 1'b0, 1'b0);
      check("preflush_count", 128'(count), 128'(3));
      cycle(1'b1, mk(12'h7FF), 1'b0, 1'b1);
      check("flush_count", 128'(count), 128'(0));
      check("flush_out_valid", 128'(out_valid), 128'(0));
      cycle(1'b0, '0, 1'b1, 1'b0);
      check("flush_stays_empty", 128'(out_valid), 128'(0));

      // Asynchronous reset between edges with two held.
      for (int i = 0; i < 2; i++) cycle(1'b1, mk(12'h300 + i), 1'b0, 1'b0);
      check("prerst_count", 128'(count), 128'(2));
      in_valid = 1'b0;
      #2 rstn = 1'b0;
      #1;
      check("async_count", 128'(count), 128'(0));
      check("async_out_valid", 128'(out_valid), 128'(0));
      check("async_in_ready", 128'(in_ready), 128'(1));
      check("async_pc", 128'(pc_out), 128'(0));
      #1 rstn = 1'b1;
      @(negedge clk);
      cycle(1'b1, mk(12'h0AA), 1'b0, 1'b0);
      check("post_rst_push", 128'(count), 128'(1));
      check("post_rst_pc", 128'(pc_out), 128'(12'h0AA));
      cycle(1'b0, '0, 1'b1, 1'b0);

      // Field integrity on an empty queue.
      b.pc = 12'h040; b.instr = 32'hDEADBEEF; b.c = 7'h55; b.alu = 3'b101; b.imm = 32'hFFFFF800;
      cycle(1'b1, b, 1'b0, 1'b0);
      check("fld_valid", 128'(out_valid), 128'(1));
      check("fld_instr", 128'(instr_out), 128'(32'hDEADBEEF));
      check("fld_imm", 128'(imm_out), 128'(32'hFFFFF800));
      check("fld_c_sig", 128'(c_sig_out), 128'(7'h55));
      check("fld_alu_sig", 128'(alu_sig_out), 128'(3'b101));
      cycle(1'b0, '0, 1'b1, 1'b0);

      // Randomized traffic with occasional flush.
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), rnd_bundle(),
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0));
      end
      cycle(1'b0, '0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
